// File: rtl/mx_pkg.sv
// Shared constants, width helper and FSM state type for the MX FP8 block encoder.
package mx_pkg;

    localparam int          E4M3_BIAS     = 7;
    localparam int          E4M3_EMAX     = 8;
    localparam logic [7:0]  E4M3_MAX_CODE = 8'h7E;
    localparam logic [7:0]  E4M3_NAN_CODE = 8'h7F;
    localparam int          E8M0_BIAS     = 127;
    localparam int          E8M0_NAN      = 255;

    // Input width wide enough to hold a full-range k-term E4M3 dot product.
    function automatic int mx_in_width(input int exp_w, input int man_w, input int blk_k);
        return 2 * ((1 << exp_w) + man_w) + $clog2(blk_k);
    endfunction

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SCALE = 2'd1,
        DRAIN = 2'd2
    } mx_enc_state_t;

endpackage

// File: rtl/mx_fp8_encoder_if.sv
// Handshake bundle of the MX encoder: fixed-point input stream and E4M3/E8M0 output stream.
interface mx_fp8_encoder_if #(
    parameter int in_width   = 43,
    parameter int elem_width = 8
);
    logic                       i_valid;
    logic                       o_ready;
    logic signed [in_width-1:0] i_data;
    logic                       o_valid;
    logic                       i_ready;
    logic [elem_width-1:0]      o_elem;
    logic [7:0]                 o_scale;
    logic                       o_last;

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_elem, o_scale, o_last
    );

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_elem, o_scale, o_last
    );
endinterface

// File: rtl/mx_fp8_round.sv
// Converts one buffered fixed-point value, divided by 2^s, into an E4M3 code.
// Rounding: MX_ENC_RNE_EN defined -> round-to-nearest-even, otherwise truncation.
module mx_fp8_round
    import mx_pkg::*;
#(
    parameter int in_width = 43
) (
    input  logic signed [in_width-1:0] value,
    input  logic signed [7:0]          s,
    output logic        [7:0]          code
);

    localparam int            mw  = in_width + 1;
    localparam logic [mw-1:0] one = mw'(1);

    logic [mw-1:0]     sext;
    logic [mw-1:0]     mag;
    logic              neg;
    logic              is_zero;
    logic [7:0]        p;
    logic signed [8:0] s_ext;
    logic signed [8:0] e_unb;
    logic signed [8:0] e_m3;
    logic signed [8:0] q;
    logic signed [8:0] t;
    logic [6:0]        sh;
    logic              normal;
    logic              round_up;
    logic [4:0]        mant;
    logic [4:0]        mant_r;
    logic [4:0]        eb5;
    logic [7:0]        code_w;
`ifdef MX_ENC_RNE_EN
    logic [mw-1:0]     rem;
    logic [mw-1:0]     half;
`endif

    always_comb begin
        neg     = value[in_width-1];
        sext    = {value[in_width-1], value};
        mag     = neg ? (~sext + one) : sext;
        is_zero = (mag == '0);

        p = '0;
        for (int i = 0; i < mw; i++) begin
            if (mag[i]) p = 8'(i);
        end

        // Quantum of the target code is 2^(E-3) for normals, 2^-9 for subnormals;
        // t is that quantum expressed as a bit position of the raw magnitude.
        s_ext  = {s[7], s};
        e_unb  = $signed({1'b0, p}) - s_ext;
        e_m3   = e_unb - 9'sd3;
        q      = (e_m3 < -9'sd9) ? -9'sd9 : e_m3;
        t      = q + s_ext;
        normal = (e_unb >= -9'sd6);

        if (t > 9'sd0) begin
            sh   = 7'(t);
            mant = 5'(mag >> sh);
        end else begin
            sh   = 7'(-t);
            mant = 5'(mag << sh);
        end

`ifdef MX_ENC_RNE_EN
        rem  = '0;
        half = one;
        if (t > 9'sd0) begin
            rem  = mag & ~({mw{1'b1}} << sh);
            half = one << (sh - 7'd1);
        end
        round_up = (rem > half) || ((rem == half) && mant[0]);
`else
        round_up = 1'b0;
`endif

        // Adding the implicit-bit mantissa onto (biased_exp-1)<<3 lets a rounding
        // carry roll naturally into the exponent field.
        mant_r = mant + 5'(round_up);
        eb5    = normal ? 5'(e_unb + 9'(E4M3_BIAS - 1)) : 5'd0;
        code_w = {eb5, 3'b000} + {3'b000, mant_r};
        if (code_w >= E4M3_NAN_CODE) code_w = E4M3_MAX_CODE;

        if (is_zero || (code_w == 8'h00)) code = 8'h00;
        else                              code = {neg, code_w[6:0]};
    end

endmodule

// File: rtl/mx_fp8_encoder.sv
// Streaming MX block encoder: buffers k fixed-point values, derives a shared E8M0 scale,
// then emits k E4M3 elements. Rounding mode selected by MX_ENC_RNE_EN (see mx_fp8_round).
//
// state | meaning
// FILL  | accept inputs into buffer, track max magnitude
// SCALE | one cycle: shared exponent from max magnitude
// DRAIN | emit buffered elements as E4M3 with shared scale
module mx_fp8_encoder
    import mx_pkg::*;
#(
    parameter int exp_width = 4,
    parameter int man_width = 3,
    parameter int k         = 32,
    parameter int in_width  = mx_in_width(exp_width, man_width, k)
) (
    input  logic          clk,
    input  logic          rst,
    mx_fp8_encoder_if.slave bus
);

    localparam int            cw       = (k > 1) ? $clog2(k) : 1;
    localparam int            mw       = in_width + 1;
    localparam int            elem_w   = 1 + exp_width + man_width;
    localparam logic [cw-1:0] last_pos = cw'(k - 1);
    localparam logic [mw-1:0] one      = mw'(1);

    mx_enc_state_t              state, state_nxt;
    logic [cw-1:0]              cnt;
    logic [cw-1:0]              idx;
    logic [mw-1:0]              max_mag;
    logic [mw-1:0]              in_sext;
    logic [mw-1:0]              in_mag;
    logic signed [in_width-1:0] data_buf [k];
    logic signed [7:0]          s_reg;
    logic [7:0]                 scale_reg;
    logic signed [7:0]          s_nxt;
    logic signed [8:0]          s_ext9;
    logic signed [8:0]          scale_sum;
    logic [7:0]                 scale_nxt;
    logic [7:0]                 lead;
    logic [7:0]                 elem_code;
    logic                       accept;
    logic                       take;

    always_comb begin
        in_sext = {bus.i_data[in_width-1], bus.i_data};
        in_mag  = in_sext[mw-1] ? (~in_sext + one) : in_sext;
        accept  = bus.i_valid && (state == FILL) && !rst;
        take    = bus.i_ready && (state == DRAIN);
    end

    always_comb begin
        lead = '0;
        for (int i = 0; i < mw; i++) begin
            if (max_mag[i]) lead = 8'(i);
        end
        s_nxt     = (max_mag == '0) ? 8'sd0 : ($signed(lead) - 8'(E4M3_EMAX));
        s_ext9    = {s_nxt[7], s_nxt};
        scale_sum = s_ext9 + 9'(E8M0_BIAS);
        if (scale_sum < 9'sd0)                     scale_nxt = 8'd0;
        else if (scale_sum > 9'(E8M0_NAN - 1))     scale_nxt = 8'(E8M0_NAN - 1);
        else                                       scale_nxt = 8'(scale_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && (cnt == last_pos)) state_nxt = SCALE;
            SCALE:   state_nxt = DRAIN;
            DRAIN:   if (take && (idx == last_pos))   state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        bus.o_ready = (state == FILL) && !rst;
        bus.o_valid = (state == DRAIN);
        bus.o_last  = (state == DRAIN) && (idx == last_pos);
        bus.o_elem  = (state == DRAIN) ? elem_w'(elem_code) : '0;
        bus.o_scale = scale_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            max_mag   <= '0;
            s_reg     <= '0;
            scale_reg <= 8'(E8M0_BIAS);
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        cnt <= (cnt == last_pos) ? '0 : cnt + 1'b1;
                        if (in_mag > max_mag) max_mag <= in_mag;
                    end
                end
                SCALE: begin
                    s_reg     <= s_nxt;
                    scale_reg <= scale_nxt;
                    max_mag   <= '0;
                end
                DRAIN: begin
                    if (take) idx <= (idx == last_pos) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Single buffer, no reset needed: every slot is rewritten before it is drained.
    always_ff @(posedge clk) begin
        if (accept) data_buf[cnt] <= bus.i_data;
    end

    mx_fp8_round #(
        .in_width (in_width)
    ) u_round (
        .value (data_buf[idx]),
        .s     (s_reg),
        .code  (elem_code)
    );

endmodule
